// File: rtl/add_pkg.sv
// Shared definitions for the byte-serial adder: octet width and sequencing states.
package add_pkg;

    localparam int OCTET_W = 8;

    typedef enum logic {
        PREMIER = 1'b0,
        SUITE   = 1'b1
    } etat_t;

endpackage

// File: rtl/add_huit.sv
// 8-bit ripple-carry adder; purely combinational datapath for the serial adder.
module add_huit
    import add_pkg::*;
(
    input  logic [OCTET_W-1:0] a,
    input  logic [OCTET_W-1:0] b,
    input  logic               rin,
    output logic [OCTET_W-1:0] s,
    output logic               rout
);

    always_comb begin
        logic carry;
        s     = '0;
        carry = rin;
        for (int unsigned i = 0; i < OCTET_W; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        rout = carry;
    end

endmodule

// File: rtl/add_serie_octets.sv
// Byte-serial multi-octet adder: LSB-first octet stream in, registered sum octet stream out,
// carry chained between beats through c_reg.
module add_serie_octets
    import add_pkg::*;
#(
    parameter int MAX_OCTETS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OCTET_W-1:0] a_octet,
    input  logic [OCTET_W-1:0] b_octet,
    input  logic               rin,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OCTET_W-1:0] s_octet,
    output logic               out_last,
    output logic               rout,
    output logic               err_long
);

    localparam int               IDX_W   = $clog2(MAX_OCTETS + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_OCTETS - 1);

    etat_t              etat_q, etat_d;
    logic [IDX_W-1:0]   idx_q;
    logic               c_reg;
    logic               carry_in;
    logic [OCTET_W-1:0] sum;
    logic               cout;
    logic               accept;
    logic               force_last;
    logic               last_eff;
    logic               rout_q;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    // An overlong packet is cut at MAX_OCTETS; the cut beat behaves exactly like a real last.
    assign force_last = (idx_q == IDX_MAX) && !in_last;
    assign last_eff   = in_last || force_last;

    add_huit u_add (
        .a    (a_octet),
        .b    (b_octet),
        .rin  (carry_in),
        .s    (sum),
        .rout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            etat_q <= PREMIER;
        end else begin
            etat_q <= etat_d;
        end
    end

    always_comb begin
        etat_d   = etat_q;
        carry_in = (etat_q == PREMIER) ? rin : c_reg;
        if (accept) begin
            etat_d = last_eff ? PREMIER : SUITE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s_octet   <= '0;
            out_last  <= 1'b0;
            rout_q    <= 1'b0;
            c_reg     <= 1'b0;
            idx_q     <= '0;
            err_long  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                s_octet   <= sum;
                c_reg     <= cout;
                out_last  <= last_eff;
                rout_q    <= last_eff ? cout : 1'b0;
                idx_q     <= last_eff ? '0 : idx_q + 1'b1;
                if (force_last) begin
                    err_long <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Final carry is only presented alongside a valid last octet.
    assign rout = rout_q && out_valid && out_last;

endmodule

// File: tb/tb_add_serie_octets.sv
// Self-checking bench for add_serie_octets: directed packets plus randomized traffic
// checked against whole-number packet arithmetic.
module tb_add_serie_octets;

    localparam int MAXO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a_octet = '0;
    logic [7:0] b_octet = '0;
    logic       rin = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] s_octet;
    logic       out_last;
    logic       rout;
    logic       err_long;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       rin;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] s;
        logic       last;
        logic       rout;
    } res_t;

    beat_t stim_q[$];
    res_t  exp_q[$];

    add_serie_octets #(.MAX_OCTETS(MAXO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_octet   (a_octet),
        .b_octet   (b_octet),
        .rin       (rin),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_octet   (s_octet),
        .out_last  (out_last),
        .rout      (rout),
        .err_long  (err_long)
    );

    always #5 clk = ~clk;

    task automatic add_beat(input logic [7:0] a, input logic [7:0] b, input logic r, input logic l);
        beat_t bt;
        bt.a = a; bt.b = b; bt.rin = r; bt.last = l;
        stim_q.push_back(bt);
    endtask

    task automatic add_exp(input logic [7:0] s, input logic l, input logic r);
        res_t rs;
        rs.s = s; rs.last = l; rs.rout = r;
        exp_q.push_back(rs);
    endtask

    // Reference: add each packet as whole integers, cutting it into MAXO-octet chunks.
    task automatic model_packet(input int first, input int len);
        int k = 0;
        while (k < len) begin
            int n;
            logic [47:0] sa;
            logic [47:0] sb;
            logic [47:0] tot;
            n  = (len - k > MAXO) ? MAXO : len - k;
            sa = '0;
            sb = '0;
            for (int i = 0; i < n; i++) begin
                sa = sa | (48'(stim_q[first + k + i].a) << (8 * i));
                sb = sb | (48'(stim_q[first + k + i].b) << (8 * i));
            end
            tot = sa + sb + 48'(stim_q[first + k].rin);
            for (int i = 0; i < n; i++) begin
                add_exp(tot[8 * i +: 8], (i == n - 1), (i == n - 1) ? tot[8 * n] : 1'b0);
            end
            k += n;
        end
    endtask

    // Drives stim_q, pops outputs, and compares them in order against exp_q.
    task automatic run_stream(input int ready_mode, input bit gaps, input string tag);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int nst;
        int nex;
        bit held = 0;
        logic [7:0] hs = '0;
        logic hl = 1'b0;
        logic hr = 1'b0;
        nst = stim_q.size();
        nex = exp_q.size();
        while ((got < nex || sent < nst) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (sent < nst && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                a_octet  = stim_q[sent].a;
                b_octet  = stim_q[sent].b;
                rin      = stim_q[sent].rin;
                in_last  = stim_q[sent].last;
            end else begin
                in_valid = 1'b0;
                a_octet  = 8'($urandom);
                b_octet  = 8'($urandom);
                rin      = 1'($urandom_range(0, 1));
                in_last  = 1'($urandom_range(0, 1));
            end
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || s_octet !== hs || out_last !== hl || rout !== hr) begin
                    failures++;
                    $display("FAIL %s hold: got v=%b s=%h l=%b r=%b required v=1 s=%h l=%b r=%b",
                             tag, out_valid, s_octet, out_last, rout, hs, hl, hr);
                end
            end
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                failures++;
                $display("FAIL %s in_ready: got %b required %b (out_valid=%b out_ready=%b)",
                         tag, in_ready, !out_valid || out_ready, out_valid, out_ready);
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (got >= nex) begin
                    failures++;
                    $display("FAIL %s extra_beat: got s=%h beyond %0d required beats", tag, s_octet, nex);
                end else if (s_octet !== exp_q[got].s || out_last !== exp_q[got].last ||
                             rout !== exp_q[got].rout) begin
                    failures++;
                    $display("FAIL %s beat%0d: got s=%h l=%b r=%b required s=%h l=%b r=%b",
                             tag, got, s_octet, out_last, rout,
                             exp_q[got].s, exp_q[got].last, exp_q[got].rout);
                end
                got++;
            end
            held = (out_valid === 1'b1) && !out_ready;
            hs = s_octet;
            hl = out_last;
            hr = rout;
            if (in_valid && in_ready === 1'b1) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != nex || sent != nst) begin
            failures++;
            $display("FAIL %s timeout: got %0d/%0d beats out, %0d/%0d in after %0d cycles",
                     tag, got, nex, sent, nst, cyc);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s drained: got out_valid=%b required 0", tag, out_valid);
        end
        stim_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (out_valid !== 1'b0 || s_octet !== 8'h00 || out_last !== 1'b0 || rout !== 1'b0 ||
            err_long !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: got v=%b s=%h l=%b r=%b err=%b rdy=%b required v=0 s=00 l=0 r=0 err=0 rdy=1",
                     tag, out_valid, s_octet, out_last, rout, err_long, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values("reset_released");
    endtask

    task automatic test_single();
        add_beat(8'd217, 8'd151, 1'b0, 1'b1);
        add_exp(8'd112, 1'b1, 1'b1);
        run_stream(0, 0, "single");
    endtask

    task automatic test_two_octet();
        add_beat(8'hD9, 8'h97, 1'b0, 1'b0);
        add_beat(8'h01, 8'h00, 1'b1, 1'b1);
        add_exp(8'h70, 1'b0, 1'b0);
        add_exp(8'h02, 1'b1, 1'b0);
        run_stream(0, 0, "two_octet");
    endtask

    task automatic test_no_leak();
        add_beat(8'hFF, 8'h01, 1'b0, 1'b1);
        add_beat(8'h00, 8'h00, 1'b0, 1'b1);
        add_exp(8'h00, 1'b1, 1'b1);
        add_exp(8'h00, 1'b1, 1'b0);
        run_stream(0, 0, "no_leak");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            add_beat(8'hFF, 8'h00, (i == 0), (i == 3));
            add_exp(8'h00, (i == 3), (i == 3));
        end
        run_stream(1, 0, "backpressure");
        checks++;
        if (err_long !== 1'b0) begin
            failures++;
            $display("FAIL backpressure err_long: got %b required 0", err_long);
        end
    endtask

    task automatic test_random();
        bit err_exp = 0;
        for (int p = 0; p < 40; p++) begin
            int len;
            int first;
            len   = $urandom_range(1, 6);
            first = stim_q.size();
            if (len > MAXO) err_exp = 1;
            for (int i = 0; i < len; i++) begin
                add_beat(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), (i == len - 1));
            end
            model_packet(first, len);
        end
        run_stream(2, 1, "random");
        checks++;
        if (err_long !== err_exp) begin
            failures++;
            $display("FAIL random err_long: got %b required %b", err_long, err_exp);
        end
    endtask

    task automatic test_reset_mid(input logic r2, input logic [7:0] s2);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; a_octet = 8'hFF; b_octet = 8'hFF; rin = 1'b0; in_last = 1'b0;
        @(negedge clk);
        a_octet = 8'hFF; b_octet = 8'hFF;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || s_octet !== 8'hFF || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid pre: got v=%b s=%h l=%b required v=1 s=ff l=0",
                     out_valid, s_octet, out_last);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("reset_mid");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        add_beat(8'h05, 8'h03, r2, 1'b1);
        add_exp(s2, 1'b1, 1'b0);
        run_stream(0, 0, "reset_mid_after");
    endtask

    task automatic test_overlength();
        checks++;
        if (err_long !== 1'b0) begin
            failures++;
            $display("FAIL overlength err_before: got %b required 0", err_long);
        end
        for (int i = 0; i < 5; i++) begin
            add_beat(8'h01, 8'h01, 1'b0, (i == 4));
            add_exp(8'h02, (i >= 3), 1'b0);
        end
        run_stream(0, 0, "overlength");
        checks++;
        if (err_long !== 1'b1) begin
            failures++;
            $display("FAIL overlength err_set: got %b required 1", err_long);
        end
        add_beat(8'h10, 8'h20, 1'b0, 1'b1);
        add_exp(8'h30, 1'b1, 1'b0);
        run_stream(0, 0, "overlength_next");
        checks++;
        if (err_long !== 1'b1) begin
            failures++;
            $display("FAIL overlength err_sticky: got %b required 1", err_long);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_octet();
        test_no_leak();
        test_backpressure();
        test_random();
        test_reset_mid(1'b0, 8'h08);
        test_reset_mid(1'b1, 8'h09);
        test_overlength();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_serie_octets.md
# add_serie_octets

Byte-serial multi-octet adder that wraps the existing 8-bit ripple adder `add_huit` as its datapath. It accepts operand pairs one octet per beat, least-significant octet first, over a valid/ready stream. It chains the carry between beats in a register and emits one registered sum octet per beat. The final carry is reported with the last octet. It sits between the operand source and any sum consumer, extending `add_huit` to arbitrary-length additions.

## Interface
Parameters:
- `MAX_OCTETS`, default 4: maximum octets per packet; the internal index counter is `$clog2(MAX_OCTETS+1)` bits wide.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand octet pair present.
- `in_ready`  out  1  block can accept an operand octet pair this cycle.
- `a_octet`  in  8  operand A octet.
- `b_octet`  in  8  operand B octet.
- `rin`  in  1  initial carry; sampled only on the first octet of a packet.
- `in_last`  in  1  marks the most-significant octet of the packet.
- `out_valid`  out  1  sum octet present.
- `out_ready`  in  1  consumer accepts the sum octet.
- `s_octet`  out  8  sum octet.
- `out_last`  out  1  this octet is the packet's last.
- `rout`  out  1  final carry out; meaningful only when `out_valid && out_last`, 0 otherwise.
- `err_long`  out  1  sticky flag: a packet exceeded `MAX_OCTETS`.

## Operation
- Input transfer happens when `in_valid && in_ready`. Output transfer happens when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is a single output register with pass-through backpressure.
- FSM states:
  - PREMIER: expecting the first octet. The carry into `add_huit` is `rin`.
  - SUITE: mid-packet. The carry into `add_huit` is the internal carry register `c_reg`.
- FSM transitions, taken only on an accepted input:
  - PREMIER → SUITE when `!in_last`.
  - SUITE → PREMIER when `in_last`.
  - PREMIER with `in_last` (single-octet packet) stays in PREMIER.
- On each accepted input:
  - `s_octet` ← `add_huit.s`.
  - `c_reg` ← `add_huit.rout`.
  - `out_last` ← `in_last`.
  - `rout` ← `in_last ? add_huit.rout : 0`.
  - index ← `in_last ? 0 : index+1`.
- Overlength rule: an accepted octet with index == `MAX_OCTETS-1` and `!in_last` is forced to be treated as last.
  - `out_last` = 1, `rout` = carry.
  - The FSM returns to PREMIER and `err_long` is set.
  - Subsequent octets start a new packet.
- `err_long` is cleared only by reset.
- Arithmetic is modulo 2^8 per octet, with the carry fully propagated across octets. There is no carry leakage between packets, because PREMIER always uses `rin`.

## Timing
- Reset values: `out_valid`=0, `s_octet`=0, `out_last`=0, `rout`=0, `err_long`=0, `c_reg`=0, index=0, FSM=PREMIER.
- `in_ready` is 1 out of reset, since it is derived combinationally from `out_valid`.
- Latency: an octet accepted at edge N is visible on the outputs after edge N. Throughput is 1 octet/cycle when `out_ready`=1.
- Outputs hold stable while `out_valid && !out_ready`.
- Simultaneous output pop and input accept in the same cycle: the register reloads and `out_valid` stays 1.
- Reset mid-packet: the partial packet is discarded, no octet is emitted, and the next accepted octet is a first octet.
- `a_octet`/`b_octet`/`rin` are don't-care when `in_valid`=0.

## Structure
- Shared package `add_pkg` holds:
  - `OCTET_W` = 8.
  - FSM state type/encoding (PREMIER, SUITE).
- Sub-module: instantiate the existing `add_huit` unchanged as the combinational datapath. No other sub-modules.

## Test plan
- Single-octet packet: A=217, B=151, `rin`=0, `in_last`=1 → one beat `s_octet`=112, `out_last`=1, `rout`=1.
- Two-octet packet: A=0x01D9, B=0x0097 (LSB first) → `s_octet`=0x70 then 0x02, `rout`=0 on the last beat.
- No carry leak between packets:
  - Packet 1 is FF+01 with last → `s_octet`=0x00, `rout`=1.
  - Packet 2 is 00+00, `rin`=0, with last → `s_octet`=0x00, `rout`=0.
- Backpressure: 4-octet FF+00 packet with `rin`=1 while `out_ready` toggles 1,0,0,1… → all octets 0x00, `rout`=1.
  - `in_ready` is low exactly while the output is held.
  - No octet is lost or duplicated.
- Overlength: `MAX_OCTETS`=4, five octets 01+01 without last → beats 4 and 5 report `out_last`=1 with `rout`=0, and `err_long`=1 sticky.
- Reset mid-packet:
  - Assert `rst_n`=0 after the second octet of a 4-octet packet → all outputs return to reset values.
  - A following single-octet packet 0x05+0x03 → `s_octet`=0x08.
